// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time capture with stuck and overflow flags
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             overflow,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise, fall;
  logic [CNT_W-1:0]       p_cnt, h_cnt, p_next, h_next, p_inc, h_inc;
  logic                   p_sat, publish, stuck_set, stuck_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign p_sat = (p_cnt == CNT_MAX);
  assign p_inc = p_sat ? p_cnt : p_cnt + CNT_ONE;
  assign h_inc = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + CNT_ONE;

  // Edges always take priority over the stuck timeout in HIGH and LOW.
  always_comb begin
    state_next = state;
    p_next     = p_cnt;
    h_next     = h_cnt;
    publish    = 1'b0;
    stuck_set  = 1'b0;
    stuck_clr  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      p_next     = '0;
      h_next     = '0;
      stuck_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_next = ARM;
          p_next     = '0;
          h_next     = '0;
        end
        ARM: begin
          p_next = '0;
          h_next = '0;
          if (rise) begin
            state_next = HIGH;
            p_next     = CNT_ONE;
            h_next     = CNT_ONE;
            stuck_clr  = 1'b1;
          end else if (fall) begin
            stuck_clr = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            p_next     = p_inc;
          end else if (p_sat) begin
            state_next = ARM;
            p_next     = '0;
            h_next     = '0;
            stuck_set  = 1'b1;
          end else begin
            p_next = p_inc;
            h_next = h_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_next = HIGH;
            publish    = 1'b1;
            p_next     = CNT_ONE;
            h_next     = CNT_ONE;
          end else if (p_sat) begin
            state_next = ARM;
            p_next     = '0;
            h_next     = '0;
            stuck_set  = 1'b1;
          end else begin
            p_next = p_inc;
          end
        end
        default: begin
          state_next = IDLE;
          p_next     = '0;
          h_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt       <= '0;
      h_cnt       <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      meas_valid  <= 1'b0;
      overflow    <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      p_cnt      <= p_next;
      h_cnt      <= h_next;
      meas_valid <= publish;
      if (publish) begin
        period_cnt <= p_cnt;
        high_cnt   <= h_cnt;
        overflow   <= p_sat;
      end
      if (stuck_set) begin
        stuck       <= 1'b1;
        stuck_level <= s;
      end else if (stuck_clr) begin
        stuck <= 1'b0;
      end
    end
  end

endmodule
